// File: rtl/multiplier_datapath_taint1bit_pkg.sv
// Shared definitions for the shift-add multiplier datapath and its control FSM:
// result-register operation encoding and the 1-bit taint combine rule.
package multiplier_datapath_taint1bit_pkg;

  typedef enum logic [1:0] {
    RS_CLEAR = 2'd0,
    RS_LOAD  = 2'd1,
    RS_SHR   = 2'd2,
    RS_HOLD  = 2'd3
  } rs_op_e;

  // Sticky taint: take the new taint when written, keep the old one otherwise,
  // and always fold in the taint of the strobe that decided the write.
  function automatic logic taint_combine(input logic sel, input logic new_t,
                                         input logic old_t, input logic strobe_t);
    return (sel ? new_t : old_t) | strobe_t;
  endfunction

  function automatic rs_op_e rs_op_decode(input logic clr, input logic ld, input logic shr);
    rs_op_e op;
    op = RS_HOLD;
    if (clr)
      op = RS_CLEAR;
    else if (ld)
      op = RS_LOAD;
    else if (shr)
      op = RS_SHR;
    return op;
  endfunction

endpackage

// File: rtl/multiplier_datapath_taint1bit_taint_reg1.sv
// Loadable data register carrying one sticky taint bit; used for the
// multiplicand and multiplier operand registers.
module taint_reg1
  import multiplier_datapath_taint1bit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             load_t,
  input  logic [WIDTH-1:0] d,
  input  logic             d_t,
  output logic [WIDTH-1:0] q,
  output logic             q_t
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q   <= '0;
      q_t <= 1'b0;
    end else begin
      if (load)
        q <= d;
      q_t <= taint_combine(load, d_t, q_t, load_t);
    end
  end

endmodule

// File: rtl/multiplier_datapath_taint1bit.sv
// Shift-add multiplier datapath with per-register taint tracking: operand
// registers, a 2*WIDTH+1 bit result/shift register and a completion flag.
module multiplier_datapath_taint1bit
  import multiplier_datapath_taint1bit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   multiplicand_in,
  input  logic               multiplicand_in_t,
  input  logic [WIDTH-1:0]   multiplier_in,
  input  logic               multiplier_in_t,
  input  logic               mdld,
  input  logic               mdld_t,
  input  logic               mrld,
  input  logic               mrld_t,
  input  logic               rsclear,
  input  logic               rsclear_t,
  input  logic               rsload,
  input  logic               rsload_t,
  input  logic               rsshr,
  input  logic               rsshr_t,
  input  logic               productDone,
  input  logic               productDone_t,
  output logic [WIDTH-1:0]   multiplierReg,
  output logic               multiplierReg_t,
  output logic [2*WIDTH-1:0] product,
  output logic               product_t,
  output logic               product_valid,
  output logic               product_valid_t
);

  logic [WIDTH-1:0] md;
  logic             md_t;
  logic [2*WIDTH:0] rs;
  logic [2*WIDTH:0] rs_next;
  logic             rs_t;
  logic             rs_t_next;
  rs_op_e           rs_op;

  taint_reg1 #(.WIDTH(WIDTH)) u_md (
    .clk    (clk),
    .rst    (rst),
    .load   (mdld),
    .load_t (mdld_t),
    .d      (multiplicand_in),
    .d_t    (multiplicand_in_t),
    .q      (md),
    .q_t    (md_t)
  );

  taint_reg1 #(.WIDTH(WIDTH)) u_mr (
    .clk    (clk),
    .rst    (rst),
    .load   (mrld),
    .load_t (mrld_t),
    .d      (multiplier_in),
    .d_t    (multiplier_in_t),
    .q      (multiplierReg),
    .q_t    (multiplierReg_t)
  );

  // The add lands in the upper half plus the carry bit, so an overflowing
  // partial sum survives until the following shift brings it back down.
  always_comb begin
    rs_op   = rs_op_decode(rsclear, rsload, rsshr);
    rs_next = rs;
    case (rs_op)
      RS_CLEAR: rs_next = '0;
      RS_LOAD:  rs_next[2*WIDTH:WIDTH] = rs[2*WIDTH:WIDTH] + {1'b0, md};
      RS_SHR:   rs_next = rs >> 1;
      default:  rs_next = rs;
    endcase
    rs_t_next = taint_combine(rs_op == RS_CLEAR, 1'b0, rs_t, rsclear_t | rsload_t | rsshr_t)
              | ((rs_op == RS_LOAD) & md_t);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rs              <= '0;
      rs_t            <= 1'b0;
      product_valid   <= 1'b0;
      product_valid_t <= 1'b0;
    end else begin
      rs   <= rs_next;
      rs_t <= rs_t_next;
      if (rsclear)
        product_valid <= 1'b0;
      else if (productDone)
        product_valid <= 1'b1;
      product_valid_t <= taint_combine(productDone | rsclear, productDone_t,
                                       product_valid_t, productDone_t | rsclear_t);
    end
  end

  assign product   = rs[2*WIDTH-1:0];
  assign product_t = rs_t;

endmodule

// File: doc/multiplier_datapath_taint1bit.md
Name: multiplier_datapath_taint1bit

Overview:
- Datapath stage of the sequential shift-add multiplier; sits directly downstream of the multiplier control FSM and consumes its strobes (mdld, mrld, rsclear, rsload, rsshr, productDone).
- Holds the multiplicand, multiplier and result-shift registers, and returns the static multiplier register to the control FSM for bit testing.
- Carries one sticky taint bit per register, plus a taint bit on every strobe and data input, so taint propagates through the whole multiply.

Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH bits.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-low.
- multiplicand_in  in  WIDTH  operand A.
- multiplicand_in_t  in  1  taint of operand A.
- multiplier_in  in  WIDTH  operand B.
- multiplier_in_t  in  1  taint of operand B.
- mdld, mdld_t  in  1,1  load multiplicand register / taint.
- mrld, mrld_t  in  1,1  load multiplier register / taint.
- rsclear, rsclear_t  in  1,1  clear result register / taint.
- rsload, rsload_t  in  1,1  add multiplicand into upper result / taint.
- rsshr, rsshr_t  in  1,1  logical shift result right by 1 / taint.
- productDone, productDone_t  in  1,1  final-step indication from control / taint.
- multiplierReg  out  WIDTH  registered multiplier, to control.
- multiplierReg_t  out  1  taint of multiplierReg, to control.
- product  out  2*WIDTH  result register bits [2*WIDTH-1:0].
- product_t  out  1  taint of result register.
- product_valid  out  1  product holds a completed result.
- product_valid_t  out  1  taint of product_valid.

Behaviour:
- Reset (rst=0, asynchronous): md, mr, rs (2*WIDTH+1 bits incl. carry), product_valid all 0; every taint bit 0. Outputs are direct register outputs, so all outputs read 0.
- md register: md <= multiplicand_in when mdld. Taint: md_t <= (mdld ? multiplicand_in_t : md_t) | mdld_t.
- mr register: same rule with mrld, multiplier_in and multiplier_in_t. mr is never shifted. multiplierReg = mr.
- rs register, one operation per cycle, priority rsclear > rsload > rsshr:
  - rsclear: rs <= 0.
  - rsload: rs[2W:W] <= rs[2W:W] + {1'b0, md}; lower half unchanged; the carry lands in rs[2W].
  - rsshr: rs <= rs >> 1, zero fill.
  - none: hold.
- rs taint:
  - base value: rsclear ? 0 : rs_t.
  - if rsload and not rsclear: OR in md_t.
  - always OR in rsclear_t | rsload_t | rsshr_t, whether or not the strobe is asserted. A tainted strobe means the register may or may not have been written.
- Intended control sequence: clear; then W rounds of (shift, optional add of bit i); then one final shift. That is W+1 shifts in total, so an add of bit i is followed by W-i shifts. product = rs[2W-1:0] = md*mr, and rs[2W] is 0 after the final shift.
- product_valid:
  - set on the edge where productDone=1; cleared on the edge where rsclear=1 (clear wins if both).
  - Net effect: product_valid rises one cycle after the FINAL state and holds until the next INIT.
  - product_valid_t <= ((productDone|rsclear) ? productDone_t : product_valid_t) | productDone_t | rsclear_t.
- Latency: product is final at the edge that ends FINAL; product_valid is high from the same edge.
- Simultaneous strobes: any mix is legal. md/mr loads are independent of the rs operation. When an rsload is masked by rsclear, its rsload_t still ORs into rs_t.
- Mid-operation reset: everything returns to 0 asynchronously; there is no partial-result retention.
- Taint is sticky: only an untainted rsclear, or an untainted load, lowers a taint bit.

Decomposition:
- Shared package: RS_OP encoding (CLEAR, LOAD, SHR, HOLD) and the taint-combine helper, also used by the control block.
- One natural sub-module, taint_reg1 (WIDTH-param data register + 1-bit taint with load/load_t rule). Instantiate it for md and mr. rs stays inline.

Test Plan:
- WIDTH=4, operands 13 and 11, all taints 0, control sequence driven: clear/load, then 4 rounds of shr with add on bits 0,1,3, then final shr -> product=143, product_t=0, product_valid=1 one cycle after productDone.
- Same run with multiplicand_in_t=1 on load only -> md_t=1 after load; product_t stays 0 until the first rsload, then 1; product unchanged at 143.
- Idle cycle with rsshr=0 and rsshr_t=1 -> rs value unchanged, product_t goes 1. A later rsclear with rsclear_t=0 -> product_t=0, product=0, product_valid=0.
- Overflow: operands 15*15 -> product=225 with the carry into rs[8] exercised mid-run; rs[8]=0 at the end.
- rst pulled low during round 2 -> all outputs 0 immediately (asynchronous, no clock edge needed); after release, a fresh 6*7 multiply gives 42.
- rsclear and productDone in the same cycle -> product_valid=0 next cycle; product_valid_t equals productDone_t|rsclear_t.
